// File: rtl/toy_pack.sv
// Shared types and constants for the toy core's dispatch-to-EU path.
package toy_pack;

    // Default receive-queue depth; dispatch resets each EU credit counter to this.
    localparam int unsigned EU_RECV_DEPTH = 4;

    // Target execution unit of an instruction.
    typedef enum logic [1:0] {
        EU_MEXT   = 2'd0,
        EU_FLOAT  = 2'd1,
        EU_CSR    = 2'd2,
        EU_CUSTOM = 2'd3
    } eu_sel_e;

    // Instruction payload carried from dispatch to an execution unit.
    typedef struct packed {
        logic [7:0]  inst_id;
        eu_sel_e     eu_sel;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [15:0] imm;
    } eu_pkg;

endpackage

// File: rtl/toy_eu_recv_ptr.sv
// Read/write pointers, full/empty detection, push/pop qualification and
// occupancy for the EU receive queue. Pointers carry one extra wrap bit.
module toy_eu_recv_ptr
    import toy_pack::*;
#(
    parameter int unsigned DEPTH = EU_RECV_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             eu_rdy,
    input  logic             flush,
    output logic             push,
    output logic             pop,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] rd_idx,
    output logic [OCC_W-1:0] occ
);

    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] ptr_diff;

    // Status and handshake qualification, all from registered pointers plus inputs.
    always_comb begin
        empty    = (wr_ptr == rd_ptr);
        full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                   (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
        pop      = !empty && eu_rdy && !flush;
        push     = in_vld && !flush && (!full || pop);
        ptr_diff = wr_ptr - rd_ptr;
        occ      = OCC_W'(ptr_diff);
        wr_idx   = wr_ptr[IDX_W-1:0];
        rd_idx   = rd_ptr[IDX_W-1:0];
    end

    // Pointer update; flush returns both pointers to zero and wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/toy_eu_recv_queue.sv
// Receive-side instruction queue in front of one execution unit. Buffers
// the valid-only dispatch stream, presents it in order under valid/ready,
// returns freed-slot credits to dispatch and supports a full flush.
module toy_eu_recv_queue
    import toy_pack::*;
#(
    parameter int unsigned DEPTH = EU_RECV_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 2)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  eu_pkg                        in_pld,
    input  logic                         flush,
    output logic                         eu_vld,
    output eu_pkg                        eu_pld,
    input  logic                         eu_rdy,
    output logic [CNT_W-1:0]             credit_ret_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         overflow_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             drop;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    eu_pkg mem [DEPTH];

    toy_eu_recv_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .in_vld (in_vld),
        .eu_rdy (eu_rdy),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .wr_idx (wr_idx),
        .rd_idx (rd_idx),
        .occ    (occ)
    );

    // Head presentation and drop detection; eu_pld reads zero while empty.
    always_comb begin
        eu_vld = !empty;
        eu_pld = empty ? '0 : mem[rd_idx];
        drop   = in_vld && full && !pop && !flush;
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= in_pld;
        end
    end

    // Credit return: one per pop, or every discarded slot (plus an in-flight push) on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_ret_cnt <= '0;
        end else if (flush) begin
            credit_ret_cnt <= CNT_W'(occ) + CNT_W'(in_vld);
        end else begin
            credit_ret_cnt <= CNT_W'(pop);
        end
    end

    // Sticky overflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (drop) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_toy_eu_recv_queue.sv
// Self-checking bench for toy_eu_recv_queue: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based reference model.
module tb_toy_eu_recv_queue;
    import toy_pack::*;

    localparam int unsigned DEPTH = EU_RECV_DEPTH;
    localparam int unsigned CNT_W = $clog2(DEPTH + 2);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_vld;
    eu_pkg            in_pld;
    logic             flush;
    logic             eu_vld;
    eu_pkg            eu_pld;
    logic             eu_rdy;
    logic [CNT_W-1:0] credit_ret_cnt;
    logic [OCC_W-1:0] occ;
    logic             overflow_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    eu_pkg m_q[$];
    bit    m_ovf;
    int    m_cred;

    toy_eu_recv_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_vld         (in_vld),
        .in_pld         (in_pld),
        .flush          (flush),
        .eu_vld         (eu_vld),
        .eu_pld         (eu_pld),
        .eu_rdy         (eu_rdy),
        .credit_ret_cnt (credit_ret_cnt),
        .occ            (occ),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic eu_pkg mk(input int id);
        eu_pkg p;
        p.inst_id = 8'(id);
        p.eu_sel  = eu_sel_e'($urandom_range(0, 3));
        p.op      = 4'($urandom);
        p.rd      = 5'($urandom);
        p.imm     = 16'($urandom);
        return p;
    endfunction

    function automatic eu_pkg model_head();
        eu_pkg h;
        h = '0;
        if (m_q.size() > 0) h = m_q[0];
        return h;
    endfunction

    // Advance the model by one clock using the inputs presented this cycle.
    function automatic void model_update();
        bit popped;
        bit was_full;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_cred = 0;
        end else if (flush) begin
            m_cred = m_q.size() + (in_vld ? 1 : 0);
            m_q.delete();
        end else begin
            popped   = (m_q.size() > 0) && eu_rdy;
            was_full = (m_q.size() == DEPTH);
            if (in_vld && was_full && !popped) m_ovf = 1'b1;
            if (popped) void'(m_q.pop_front());
            if (in_vld && (!was_full || popped)) m_q.push_back(in_pld);
            m_cred = popped ? 1 : 0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("eu_vld", 64'(eu_vld), 64'(m_q.size() > 0));
            check("eu_pld", 64'(eu_pld), 64'(model_head()));
            check("occ", 64'(occ), 64'(m_q.size()));
            check("credit_ret_cnt", 64'(credit_ret_cnt), 64'(m_cred));
            check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        end
    end

    initial begin
        rst    = 1'b1;
        in_vld = 1'b0;
        flush  = 1'b0;
        eu_rdy = 1'b0;
        in_pld = '0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_eu_vld", 64'(eu_vld), 64'd0);
        check("rst_eu_pld", 64'(eu_pld), 64'd0);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_credit", 64'(credit_ret_cnt), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        rst = 1'b0;

        // Fill ids 1..4 with the EU stalled
        for (int id = 1; id <= 4; id++) begin
            in_vld = 1'b1;
            in_pld = mk(id);
            step();
        end
        in_vld = 1'b0;
        check("fill_occ", 64'(occ), 64'd4);
        check("fill_ovf", 64'(overflow_err), 64'd0);
        check("fill_head", 64'(eu_pld.inst_id), 64'd1);

        // Drain in order, one credit per cycle
        eu_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("drain_credit", 64'(credit_ret_cnt), 64'd1);
            if (k < 4) check("drain_head", 64'(eu_pld.inst_id), 64'(k + 1));
        end
        check("drain_empty", 64'(eu_vld), 64'd0);
        step();
        check("drain_credit_end", 64'(credit_ret_cnt), 64'd0);

        // Refill, then full pass-through with id 5 every cycle
        eu_rdy = 1'b0;
        for (int id = 1; id <= 4; id++) begin
            in_vld = 1'b1;
            in_pld = mk(id);
            step();
        end
        eu_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_pld = mk(5);
            step();
            check("pass_occ", 64'(occ), 64'd4);
            check("pass_ovf", 64'(overflow_err), 64'd0);
            check("pass_credit", 64'(credit_ret_cnt), 64'd1);
            check("pass_head", 64'(eu_pld.inst_id), (k <= 3) ? 64'(k + 1) : 64'd5);
        end

        // Overflow: push id 9 into a full, stalled queue
        eu_rdy = 1'b0;
        in_pld = mk(9);
        step();
        in_vld = 1'b0;
        check("ovf_flag", 64'(overflow_err), 64'd1);
        check("ovf_occ", 64'(occ), 64'd4);
        check("ovf_credit", 64'(credit_ret_cnt), 64'd0);
        check("ovf_head", 64'(eu_pld.inst_id), 64'd5);

        // Bring occupancy to 3, then flush with an in-flight push
        eu_rdy = 1'b1;
        step();
        check("pre_flush_occ", 64'(occ), 64'd3);
        flush  = 1'b1;
        in_vld = 1'b1;
        in_pld = mk(6);
        step();
        flush  = 1'b0;
        in_vld = 1'b0;
        check("flush_eu_vld", 64'(eu_vld), 64'd0);
        check("flush_occ", 64'(occ), 64'd0);
        check("flush_credit", 64'(credit_ret_cnt), 64'd4);
        check("flush_ovf_sticky", 64'(overflow_err), 64'd1);
        step();
        check("post_flush_credit", 64'(credit_ret_cnt), 64'd0);

        // Empty latency: no bypass
        in_vld = 1'b1;
        in_pld = mk(7);
        check("lat_before", 64'(eu_vld), 64'd0);
        step();
        in_vld = 1'b0;
        check("lat_vld", 64'(eu_vld), 64'd1);
        check("lat_head", 64'(eu_pld.inst_id), 64'd7);

        // Mid-operation reset with two entries buffered
        eu_rdy = 1'b0;
        in_vld = 1'b1;
        in_pld = mk(8);
        step();
        in_vld = 1'b0;
        check("mid_occ", 64'(occ), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_eu_vld", 64'(eu_vld), 64'd0);
        check("mid_rst_eu_pld", 64'(eu_pld), 64'd0);
        check("mid_rst_occ", 64'(occ), 64'd0);
        check("mid_rst_credit", 64'(credit_ret_cnt), 64'd0);
        check("mid_rst_ovf", 64'(overflow_err), 64'd0);
        in_vld = 1'b1;
        in_pld = mk(10);
        step();
        in_vld = 1'b0;
        check("post_rst_vld", 64'(eu_vld), 64'd1);
        check("post_rst_head", 64'(eu_pld.inst_id), 64'd10);

        // Randomized traffic including flushes, overflows and resets
        for (int c = 0; c < 3000; c++) begin
            in_vld = ($urandom_range(0, 99) < 60);
            eu_rdy = ($urandom_range(0, 99) < 50);
            flush  = ($urandom_range(0, 99) < 4);
            rst    = ($urandom_range(0, 199) < 1);
            in_pld = mk($urandom_range(0, 255));
            step();
        end
        in_vld = 1'b0;
        eu_rdy = 1'b1;
        flush  = 1'b0;
        rst    = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) step();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toy_eu_recv_queue.md
# toy_eu_recv_queue

Receive-side queue at the input of one execution unit (mext, float, csr or custom). It captures the valid-only `eu_pkg` stream produced by the dispatch crossbar, buffers up to DEPTH instructions, and presents them in order to the EU under a valid/ready handshake. It returns freed-slot credits to dispatch, so dispatch never drives a valid into a full queue, and it supports a full pipeline flush.

## Interface
Parameters:
- DEPTH, 4, number of buffered entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+2), width of the credit return count.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_vld  in  1  instruction valid from dispatch crossbar; no ready is returned.
- in_pld  in  eu_pkg  instruction payload, sampled when in_vld=1.
- flush  in  1  pipeline flush; discards all buffered entries.
- eu_vld  out  1  head entry valid toward the EU.
- eu_pld  out  eu_pkg  head entry payload.
- eu_rdy  in  1  EU accepts the head entry when eu_vld && eu_rdy.
- credit_ret_cnt  out  CNT_W  number of slots freed in the previous cycle; dispatch adds this to its credit counter.
- occ  out  $clog2(DEPTH+1)  current occupancy.
- overflow_err  out  1  sticky flag: a push was dropped because the queue was full.

## Operation
- Storage: circular buffer of DEPTH `eu_pkg` entries.
  - Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits each; the MSB is the wrap bit.
  - empty = pointers equal. full = index bits equal and wrap bits differ.
- push = in_vld && !flush && (!full || pop).
  - A push into a full queue in the same cycle as a pop is accepted.
- pop = eu_vld && eu_rdy && !flush.
- Order is strictly in order: eu_pld always equals mem[rd_ptr]; eu_vld = !empty.
- Drop rule: if in_vld && full && !pop && !flush, the entry is dropped and overflow_err is set.
  - overflow_err is cleared only by rst. A flush does not clear it.
- Flush: wr_ptr and rd_ptr are set to 0 and occupancy goes to 0.
  - Flush wins over a simultaneous push and a simultaneous pop.
  - A handshake in the flush cycle is not a transfer; the EU must ignore it.
- Credits:
  - Without flush: next credit_ret_cnt = pop (0 or 1).
  - With flush: next credit_ret_cnt = occ + in_vld. A discarded in-flight push returns its credit, which keeps the dispatch counter consistent.
- A dropped overflow push returns no credit. It is an error condition, not a flow-control case.
- No bypass: an entry pushed into an empty queue appears on eu_vld the next cycle.

## Timing
- Reset values: eu_vld=0, eu_pld=0, credit_ret_cnt=0, occ=0, overflow_err=0, both pointers=0.
- Memory contents are don't-care after reset. eu_pld is forced to 0 while empty.
- Push to visibility: in_vld at cycle N gives eu_vld=1 at N+1.
- Pop to credit: a pop at cycle N gives credit_ret_cnt=1 at N+1. Round-trip credit latency to dispatch is 2 cycles.
- Back-to-back: sustains one push and one pop per cycle at any occupancy, including 0 (after the first fill) and DEPTH.
- Wrap: pointers wrap modulo 2*DEPTH with no bubble.
- Flush at cycle N: eu_vld=0 and occ=0 at N+1. A push at N+1 is accepted normally.
- Reset mid-operation: rst overrides flush, push and pop. No credit is returned for entries lost to reset; dispatch resets its counter to DEPTH.
- Outputs eu_vld, eu_pld, occ, credit_ret_cnt and overflow_err are all registered or derived only from registered state. There is no combinational path from in_vld or eu_rdy to any output.

## Structure
- toy_pack holds:
  - `eu_pkg` (existing).
  - New constant EU_RECV_DEPTH = 4, the default for DEPTH and for the dispatch credit counter reset value.
- Optional sub-module: toy_eu_recv_ptr, the pointer, full/empty and occupancy logic, parameterised by DEPTH.
- The payload RAM is a flop array inside toy_eu_recv_queue.
- One instance per EU. The dispatch side keeps one credit counter per EU, reset to EU_RECV_DEPTH.

## Test plan
- Fill/drain, DEPTH=4, eu_rdy=0:
  - Push ids 1..4 on consecutive cycles: occ=4, no overflow_err.
  - Raise eu_rdy: ids 1,2,3,4 pop on consecutive cycles, credit_ret_cnt=1 for 4 consecutive cycles, then 0.
- Full pass-through: with occ=4 and eu_rdy=1, push id 5 every cycle for 8 cycles.
  - Occ stays 4, order is preserved, pointers wrap, no overflow_err.
- Overflow: with occ=4 and eu_rdy=0, push id 9.
  - Id 9 is dropped, overflow_err=1 from the next cycle and stays set after a later flush.
  - occ=4, no credit returned.
- Flush with in-flight push: with occ=3 and eu_rdy=1, assert flush and in_vld together.
  - Next cycle: eu_vld=0, occ=0, credit_ret_cnt=4.
  - The following cycle: credit_ret_cnt=0.
- Empty latency: push id 7 into an empty queue at cycle N.
  - eu_vld=1 with eu_pld.inst_id=7 at N+1, not at N.
- Mid-operation reset: with occ=2, assert rst for 1 cycle.
  - All outputs read their reset values next cycle.
  - A subsequent push is visible one cycle later.
